// File: rtl/reg_bank_pkg.sv
// Shared types and default sizes for the architectural register bank.
package reg_bank_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } rb_state_t;

   localparam int RB_DATA_W   = 32;
   localparam int RB_DEPTH    = 32;
   localparam int RB_NUM_READ = 2;

endpackage

// File: rtl/reg_bank_clear_fsm.sv
// Clear sequencer: walks every entry once after reset or clear_req, then idles.
module reg_bank_clear_fsm
   import reg_bank_pkg::*;
#(
   parameter int DEPTH  = RB_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_req_i,
   output logic              ready_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o
);

   rb_state_t         state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // clear_req during CLEAR falls through untouched, so a running clear is never restarted
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         CLEAR: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == ADDR_W'(DEPTH - 1)) begin
               state_d = IDLE;
               idx_d   = '0;
            end
         end
         IDLE: begin
            if (clear_req_i) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   assign ready_o    = (state_q == IDLE);
   assign clr_we_o   = (state_q == CLEAR);
   assign clr_addr_o = idx_q;

endmodule

// File: rtl/reg_bank_param.sv
// Architectural register file: one write port, NUM_READ registered read ports, r0 reads as zero.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module reg_bank_param
   import reg_bank_pkg::*;
#(
   parameter int DATA_W   = RB_DATA_W,
   parameter int DEPTH    = RB_DEPTH,
   parameter int NUM_READ = RB_NUM_READ,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       RegWrite,
   input  logic [ADDR_W-1:0]          WriteReg,
   input  logic [DATA_W-1:0]          WriteData,
   input  logic [NUM_READ*ADDR_W-1:0] ReadSel,
   output logic [NUM_READ*DATA_W-1:0] ReadData,
   input  logic                       clear_req,
   output logic                       ready
);

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              usr_we, we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] mem_q [DEPTH];

   reg_bank_clear_fsm #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk         (clk),
      .reset       (reset),
      .clear_req_i (clear_req),
      .ready_o     (ready),
      .clr_we_o    (clr_we),
      .clr_addr_o  (clr_addr)
   );

   // A clear request in the same cycle wins over the user write
   assign usr_we = ready & RegWrite & (WriteReg != '0) & ~clear_req & ~reset;
   assign we     = clr_we | usr_we;
   assign waddr  = clr_we ? clr_addr : WriteReg;
   assign wdata  = clr_we ? '0 : WriteData;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [ADDR_W-1:0] sel;
      logic [DATA_W-1:0] rd_d, rd_q;

      assign sel = ReadSel[k*ADDR_W +: ADDR_W];

      always_comb begin
         rd_d = mem_q[sel];
         if (!ready || sel == '0) rd_d = '0;
`ifdef REGFILE_BYPASS_EN
         else if (usr_we && WriteReg == sel) rd_d = WriteData;
`endif
      end

      always_ff @(posedge clk) begin
         if (reset) rd_q <= '0;
         else       rd_q <= rd_d;
      end

      assign ReadData[k*DATA_W +: DATA_W] = rd_q;
   end

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed bench for reg_bank_param at default sizes; expectations follow REGFILE_BYPASS_EN.
module tb_reg_bank_param;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [9:0]  ReadSel;
   logic [63:0] ReadData;
   logic        clear_req;
   logic        ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic [4:0]  s0, s1;
      logic [31:0] e0, e1;
   } vec_t;

   vec_t tbl [10];

   reg_bank_param #(
      .DATA_W   (32),
      .DEPTH    (32),
      .NUM_READ (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadSel   (ReadSel),
      .ReadData  (ReadData),
      .clear_req (clear_req),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sel(input logic [4:0] a0, input logic [4:0] a1);
      ReadSel = {a1, a0};
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      RegWrite  = 1'b1;
      WriteReg  = a;
      WriteData = d;
      step();
      RegWrite  = 1'b0;
   endtask

   task automatic clear_window(input string name);
      for (int c = 0; c < 32; c++) begin
         chk({name, " ready low"}, {31'b0, ready}, 32'h0);
         step();
      end
      chk({name, " ready high at 32"}, {31'b0, ready}, 32'h1);
   endtask

   initial begin
      reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
      ReadSel = '0; clear_req = 1'b0;

      tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0, 32'h0};
      tbl[1] = '{1'b1, 5'd31, 32'h12345678, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678};
      tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0, 32'h0};
      tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
      tbl[5] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd5,  BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF};
      tbl[6] = '{1'b0, 5'd7,  32'h11111111, 5'd7,  5'd31, 32'hA5A5A5A5, 32'h12345678};
      tbl[7] = '{1'b0, 5'd7,  32'h11111111, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
      tbl[8] = '{1'b1, 5'd9,  32'h0BADF00D, 5'd31, 5'd9,  32'h12345678, BYP ? 32'h0BADF00D : 32'h0};
      tbl[9] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  32'h0BADF00D, 32'h0};

      // reset state and post-reset clear window
      step();
      chk("reset ready", {31'b0, ready}, 32'h0);
      chk("reset rd0", ReadData[31:0], 32'h0);
      chk("reset rd1", ReadData[63:32], 32'h0);
      reset = 1'b0;
      for (int c = 0; c < 32; c++) begin
         chk("t1 ready low", {31'b0, ready}, 32'h0);
         sel(5'(c), 5'(31 - c));
         step();
         chk("t1 rd0", ReadData[31:0], 32'h0);
         chk("t1 rd1", ReadData[63:32], 32'h0);
      end
      chk("t1 ready high at 32", {31'b0, ready}, 32'h1);
      for (int i = 0; i < 32; i++) begin
         sel(5'(i), 5'(31 - i));
         step();
         chk("t1 idle rd0", ReadData[31:0], 32'h0);
         chk("t1 idle rd1", ReadData[63:32], 32'h0);
      end

      // write/read vectors
      for (int i = 0; i < 10; i++) begin
         RegWrite  = tbl[i].we;
         WriteReg  = tbl[i].wreg;
         WriteData = tbl[i].wdata;
         sel(tbl[i].s0, tbl[i].s1);
         step();
         chk($sformatf("vec%0d rd0", i), ReadData[31:0], tbl[i].e0);
         chk($sformatf("vec%0d rd1", i), ReadData[63:32], tbl[i].e1);
         chk($sformatf("vec%0d ready", i), {31'b0, ready}, 32'h1);
      end
      RegWrite = 1'b0;

      // fill, clear_req with a colliding write, writes and re-request during CLEAR
      for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000_0000 | 32'(i));
      sel(5'd3, 5'd30);
      step();
      chk("t5 fill rd0", ReadData[31:0], 32'h1000_0003);
      chk("t5 fill rd1", ReadData[63:32], 32'h1000_001E);
      clear_req = 1'b1; RegWrite = 1'b1; WriteReg = 5'd2; WriteData = 32'hFFFF_0002;
      sel(5'd2, 5'd2);
      step();
      clear_req = 1'b0; RegWrite = 1'b0;
      chk("t5 req-cycle rd0", ReadData[31:0], 32'h1000_0002);
      for (int c = 0; c < 32; c++) begin
         chk("t5 ready low", {31'b0, ready}, 32'h0);
         if (c == 20) begin RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h3333_3333; end
         if (c == 25) clear_req = 1'b1;
         sel(5'd3, 5'd31);
         step();
         RegWrite = 1'b0; clear_req = 1'b0;
         chk("t5 clear rd0", ReadData[31:0], 32'h0);
         chk("t5 clear rd1", ReadData[63:32], 32'h0);
      end
      chk("t5 ready high at 32", {31'b0, ready}, 32'h1);
      for (int i = 0; i < 32; i++) begin
         sel(5'(i), 5'((i + 16) % 32));
         step();
         chk("t5 post rd0", ReadData[31:0], 32'h0);
         chk("t5 post rd1", ReadData[63:32], 32'h0);
      end

      // reset in the middle of a clear restarts the full window
      wr(5'd4, 32'h4444_4444);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int c = 0; c < 10; c++) step();
      chk("t6 ready low mid-clear", {31'b0, ready}, 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6 reset rd0", ReadData[31:0], 32'h0);
      clear_window("t6");
      sel(5'd4, 5'd0);
      step();
      chk("t6 reg4 cleared", ReadData[31:0], 32'h0);
      wr(5'd4, 32'h5555_AAAA);
      step();
      chk("t6 reg4 writable", ReadData[31:0], 32'h5555_AAAA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_bank_param.md
# reg_bank_param

Parametrised, clocked register bank: one write port, `NUM_READ` registered read ports, register 0 hardwired to zero. After reset or on request, a built-in sequencer zeroes every entry, one per cycle. It is the CPU datapath's architectural register file, fed by the writeback stage and read by decode.

## Interface

Parameters:
- `DATA_W`, 32, register width in bits.
- `DEPTH`, 32, number of registers; power of two, ≥2.
- `NUM_READ`, 2, number of read ports, ≥1.
- `ADDR_W`, `$clog2(DEPTH)`, derived; not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `RegWrite`  in  1  write enable.
- `WriteReg`  in  `ADDR_W`  write address.
- `WriteData`  in  `DATA_W`  write data.
- `ReadSel`  in  `NUM_READ*ADDR_W`  packed read addresses; port k is `[k*ADDR_W +: ADDR_W]`.
- `ReadData`  out  `NUM_READ*DATA_W`  packed registered read data; port k is `[k*DATA_W +: DATA_W]`.
- `clear_req`  in  1  one-cycle pulse that starts a full clear.
- `ready`  out  1  high when the bank accepts writes; low during a clear.

## Operation

Sequencer states:
- `CLEAR`
  - Counter `clr_idx` runs from 0 to DEPTH-1.
  - Each cycle writes 0 to entry `clr_idx`.
  - After writing DEPTH-1, goes to `IDLE`.
- `IDLE`
  - Normal operation.
  - `clear_req`=1 goes to `CLEAR` with `clr_idx`=0.

Reset behaviour:
- Reset forces `CLEAR`, `clr_idx`=0, `ready`=0 and all `ReadData`=0.
- Reset asserted mid-clear restarts the clear at index 0.

Writes:
- Accepted only in `IDLE` with `RegWrite`=1 and `WriteReg`≠0.
- A write to address 0 is silently dropped.
- Writes issued while `ready`=0 are dropped; there is no backpressure and no queueing.

Reads:
- Each port samples `ReadSel` every cycle in every state.
- Address 0 always returns 0.
- During `CLEAR`, read ports return 0 for every address.

Other rules:
- Multiple ports may read the same address; each gets the same value.
- `clear_req` while already in `CLEAR` is ignored; the current clear is not restarted.
- `clear_req` and `RegWrite` in the same `IDLE` cycle: the write is dropped and the clear starts.

## Timing

- Read latency is 1 cycle: `ReadSel` sampled at edge N appears on `ReadData` after edge N and holds until edge N+1.
- Write latency is 1 cycle: the entry updates at the edge where the write is sampled.
- Read of an address written in the same cycle: behaviour depends on `REGFILE_BYPASS_EN` (see Configuration).
- Clear duration:
  - `ready` falls the cycle after `reset` or `clear_req` is sampled.
  - It stays low for exactly DEPTH cycles, then rises.
  - The first write accepted after reset release is at cycle DEPTH.
- `ready` is registered and changes only on clock edges.

## Configuration

Macro `REGFILE_BYPASS_EN`:
- Defined: same-cycle write-to-read forwarding. If `RegWrite`=1, `ready`=1 and `WriteReg`=`ReadSel[k]`≠0, port k returns `WriteData` next cycle.
- Undefined: port k returns the pre-write contents; the new value is visible one cycle later.
- Address 0 returns 0 in both builds.

## Structure

Package `reg_bank_pkg` holds:
- state enum `rb_state_t` (`CLEAR`, `IDLE`);
- default parameter constants `RB_DATA_W`, `RB_DEPTH`, `RB_NUM_READ`.

Sub-module `reg_bank_clear_fsm` holds:
- the state register and `clr_idx` counter;
- outputs `ready`, `clr_we` and `clr_addr`.

The top-level module holds the storage array, write mux (clear vs. user) and read ports; read ports come from a `generate` loop.

## Test plan

All tests use defaults (DATA_W=32, DEPTH=32, NUM_READ=2).

1. Reset release, read all 32 addresses → `ready`=0 for cycles 0–31, `ready`=1 at cycle 32, every read = 0x00000000.
2. Write 0xDEADBEEF to reg 5 and 0x12345678 to reg 31, then read port0=5, port1=31 → next cycle `ReadData` = {0x12345678, 0xDEADBEEF}.
3. Write 0xFFFFFFFF to reg 0, then read reg 0 on both ports → both return 0.
4. Write 0xA5A5A5A5 to reg 7 while port0 reads 7 in the same cycle → `REGFILE_BYPASS_EN` build: 0xA5A5A5A5 next cycle; no-bypass build: old value, then 0xA5A5A5A5 one cycle later.
5. Fill regs 1–31, pulse `clear_req`, write reg 3 during `CLEAR` → write dropped, `ready` low for 32 cycles, afterwards all reads = 0.
6. Assert `reset` at `clr_idx`=10 during a clear → `clr_idx` restarts at 0 and `ready` rises exactly 32 cycles after `reset` deasserts.
